// File: rtl/unroller_out_reg.sv
// Vector register slice: captures a full vector on load and holds it
// until the consumer takes it with valid && ready.
module unroller_out_reg #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data [NUM],
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data [NUM],
    output logic                  valid
);

    // A load takes priority over the consume, so a slot freed by the
    // consumer can be refilled in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                data[i] <= '0;
            end
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/unroller.sv
// Reassembles NUM/ROLL_NUM consecutive ROLL_NUM-element chunks into one
// NUM-element vector; the first chunk of a group fills the lowest indices.
module unroller #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM        = 8,
    parameter int ROLL_NUM   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [ROLL_NUM],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [NUM],
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    localparam int CYCLES = NUM / ROLL_NUM;
    localparam int CW     = $clog2(CYCLES) + 1;

    if (NUM % ROLL_NUM != 0) begin : g_bad_cfg
        $error("unroller: NUM (%0d) must be a multiple of ROLL_NUM (%0d)", NUM, ROLL_NUM);
    end

    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic [CW-1:0]         slot;
    logic [DATA_WIDTH-1:0] col [NUM];
    logic                  col_full;
    logic                  out_free;
    logic                  xfer;
    logic                  accept;

    // data_in_ready depends combinationally on data_out_ready so that a full
    // collect buffer can hand off and take a new chunk in the same cycle.
    assign col_full      = (cnt == CW'(CYCLES));
    assign out_free      = !data_out_valid || data_out_ready;
    assign xfer          = col_full && out_free;
    assign data_in_ready = !col_full || xfer;
    assign accept        = data_in_valid && data_in_ready;
    assign slot          = xfer ? '0 : cnt;

    always_comb begin
        cnt_next = cnt;
        if (xfer && accept) begin
            cnt_next = CW'(1);
        end else if (xfer) begin
            cnt_next = '0;
        end else if (accept) begin
            cnt_next = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            for (int i = 0; i < NUM; i++) begin
                col[i] <= '0;
            end
        end else begin
            cnt <= cnt_next;
            for (int k = 0; k < CYCLES; k++) begin
                if (accept && slot == CW'(k)) begin
                    for (int i = 0; i < ROLL_NUM; i++) begin
                        col[k*ROLL_NUM + i] <= data_in[i];
                    end
                end
            end
        end
    end

    unroller_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM        (NUM)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (xfer),
        .load_data (col),
        .ready     (data_out_ready),
        .data      (data_out),
        .valid     (data_out_valid)
    );

endmodule

// File: tb/tb_unroller.sv
// Directed and scoreboard bench for unroller (NUM=8/ROLL_NUM=2 plus a
// NUM=4/ROLL_NUM=4 instance for the single-chunk-per-vector case).
module tb_unroller;

    localparam int DW = 16;

    typedef struct {
        logic      v;
        int        d0;
        int        d1;
        logic      ordy;
        logic      exp_irdy;
        logic      exp_ov;
        int        exp_base;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in [2];
    logic          data_in_valid;
    logic          data_in_ready;
    logic [DW-1:0] data_out [8];
    logic          data_out_valid;
    logic          data_out_ready;

    logic [DW-1:0] d4_in [4];
    logic          d4_in_valid;
    logic          d4_in_ready;
    logic [DW-1:0] d4_out [4];
    logic          d4_out_valid;
    logic          d4_out_ready;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    unroller #(.DATA_WIDTH(DW), .NUM(8), .ROLL_NUM(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    unroller #(.DATA_WIDTH(DW), .NUM(4), .ROLL_NUM(4)) dut4 (
        .clk            (clk),
        .rst            (rst),
        .data_in        (d4_in),
        .data_in_valid  (d4_in_valid),
        .data_in_ready  (d4_in_ready),
        .data_out       (d4_out),
        .data_out_valid (d4_out_valid),
        .data_out_ready (d4_out_ready)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkVec(input string name, input logic [DW-1:0] act [8], input logic [DW-1:0] exp [8]);
        logic ok;
        ok = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (act[j] !== exp[j]) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: got %0d %0d %0d %0d %0d %0d %0d %0d expected %0d %0d %0d %0d %0d %0d %0d %0d",
                     name, act[0], act[1], act[2], act[3], act[4], act[5], act[6], act[7],
                     exp[0], exp[1], exp[2], exp[3], exp[4], exp[5], exp[6], exp[7]);
        end
    endtask

    task automatic addRow(input logic v, input int d0, input int d1, input logic ordy,
                          input logic irdy, input logic ov, input int base);
        vec_t r;
        r.v = v; r.d0 = d0; r.d1 = d1; r.ordy = ordy;
        r.exp_irdy = irdy; r.exp_ov = ov; r.exp_base = base;
        tbl.push_back(r);
    endtask

    task automatic applyStimulus(input vec_t r);
        data_in_valid  = r.v;
        data_in[0]     = DW'(r.d0);
        data_in[1]     = DW'(r.d1);
        data_out_ready = r.ordy;
    endtask

    // base == 0 means an all-zero vector, otherwise elements base..base+7
    task automatic checkOutput(input string name, input logic irdy, input logic ov, input int base);
        logic [DW-1:0] exp [8];
        for (int j = 0; j < 8; j++) exp[j] = (base == 0) ? '0 : DW'(base + j);
        check1({name, " in_ready"}, data_in_ready, irdy);
        check1({name, " out_valid"}, data_out_valid, ov);
        checkVec({name, " data_out"}, data_out, exp);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DW-1:0] exp [8];
        logic [DW-1:0] act [8];
        logic          acc;
        int            nvec;
        int            sent;
        int            vexp;
        int            cyc;

        rst = 1'b0;
        data_in_valid = 1'b0; data_out_ready = 1'b1;
        data_in[0] = '0; data_in[1] = '0;
        d4_in_valid = 1'b0; d4_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) d4_in[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset", 1'b1, 1'b0, 0);
        check1("reset d4 in_ready", d4_in_ready, 1'b1);
        check1("reset d4 out_valid", d4_out_valid, 1'b0);
        rst = 1'b1;

        // stream and back-to-back vectors
        addRow(1,  1,  2, 1, 1, 0, 0);
        addRow(1,  3,  4, 1, 1, 0, 0);
        addRow(1,  5,  6, 1, 1, 0, 0);
        addRow(1,  7,  8, 1, 1, 0, 0);
        addRow(1,  9, 10, 1, 1, 0, 0);
        addRow(1, 11, 12, 1, 1, 1, 1);
        addRow(1, 13, 14, 1, 1, 0, 1);
        addRow(1, 15, 16, 1, 1, 0, 1);
        addRow(0, 16'hdead, 16'hbeef, 1, 1, 0, 1);
        addRow(0, 0, 0, 0, 1, 1, 9);
        addRow(0, 0, 0, 1, 1, 1, 9);
        addRow(0, 0, 0, 1, 1, 0, 9);
        // backpressure with data_out_ready held low
        addRow(1, 21, 22, 0, 1, 0, 9);
        addRow(1, 23, 24, 0, 1, 0, 9);
        addRow(1, 25, 26, 0, 1, 0, 9);
        addRow(1, 27, 28, 0, 1, 0, 9);
        addRow(1, 29, 30, 0, 1, 0, 9);
        addRow(1, 31, 32, 0, 1, 1, 21);
        addRow(1, 33, 34, 0, 1, 1, 21);
        addRow(1, 35, 36, 0, 1, 1, 21);
        addRow(1, 99, 99, 0, 0, 1, 21);
        addRow(1, 99, 99, 0, 0, 1, 21);
        addRow(0,  0,  0, 1, 1, 1, 21);
        addRow(0,  0,  0, 1, 1, 1, 29);
        addRow(0,  0,  0, 1, 1, 0, 29);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            applyStimulus(tbl[i]);
            #1;
            checkOutput($sformatf("row%0d", i), tbl[i].exp_irdy, tbl[i].exp_ov, tbl[i].exp_base);
        end

        // mid-group reset discards the partial group
        @(negedge clk);
        data_in_valid = 1'b1; data_in[0] = 16'd1; data_in[1] = 16'd2; data_out_ready = 1'b1;
        @(negedge clk);
        data_in[0] = 16'd3; data_in[1] = 16'd4;
        @(negedge clk);
        rst = 1'b0; data_in_valid = 1'b0;
        #1;
        check1("in reset out_valid", data_out_valid, 1'b0);
        check1("in reset in_ready", data_in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("after reset", 1'b1, 1'b0, 0);
        exp = '{16'd9, 16'd9, 16'd8, 16'd8, 16'd7, 16'd7, 16'd6, 16'd6};
        nvec = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            data_in_valid = (c < 4);
            data_in[0] = DW'(9 - c);
            data_in[1] = DW'(9 - c);
            #1;
            if (data_out_valid) begin
                nvec++;
                if (nvec == 1) checkVec("midreset vector", data_out, exp);
            end
        end
        checkInt("midreset vector count", nvec, 1);

        // random bubbles and backpressure against an in-order scoreboard
        sent = 0; vexp = 0; cyc = 0;
        while (vexp < 250 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (sent < 1000) begin
                data_in[0]     = DW'(2*sent + 1);
                data_in[1]     = DW'(2*sent + 2);
                data_in_valid  = ($urandom_range(0, 3) != 0);
                data_out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                data_in_valid  = 1'b0;
                data_out_ready = 1'b1;
            end
            #1;
            acc = data_in_valid && data_in_ready;
            if (data_out_valid && data_out_ready) begin
                for (int j = 0; j < 8; j++) exp[j] = DW'(vexp*8 + j + 1);
                checkVec($sformatf("random vector %0d", vexp), data_out, exp);
                vexp++;
            end
            if (acc) sent++;
        end
        checkInt("random vectors received", vexp, 250);
        nvec = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            data_in_valid = 1'b0; data_out_ready = 1'b1;
            #1;
            if (data_out_valid) nvec++;
        end
        checkInt("random extra vectors", nvec, 0);

        // single chunk per vector
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            d4_in_valid = (c < 3);
            for (int i = 0; i < 4; i++) d4_in[i] = DW'(4*c + i + 1);
            d4_out_ready = 1'b1;
            #1;
            check1($sformatf("d4 cycle%0d in_ready", c), d4_in_ready, 1'b1);
            check1($sformatf("d4 cycle%0d out_valid", c), d4_out_valid, (c >= 2 && c < 5));
            if (c >= 2 && c < 5) begin
                for (int j = 0; j < 8; j++) begin
                    act[j] = (j < 4) ? d4_out[j] : '0;
                    exp[j] = (j < 4) ? DW'(4*(c-2) + j + 1) : '0;
                end
                checkVec($sformatf("d4 cycle%0d data_out", c), act, exp);
            end
        end
        d4_in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
